spi_dac_rx: RTL
===============

SPI_DAC_RX -- requirements
Module: spi_dac_rx

Interface
REQ-001 Parameter FRAME_BITS, default 16, is the number of SDI bits in one valid frame.
REQ-002 Parameter SYNC_STAGES, default 2, is the synchronizer depth applied to n_CS, SCK and SDI; legal values are 2 or more.
REQ-003 clk  input  1  is the single system clock; all state is in this domain.
REQ-004 rst  input  1  is the reset, asynchronous and active-low (0 = reset).
REQ-005 n_CS  input  1  is the SPI chip select, active-low and asynchronous to clk.
REQ-006 SCK  input  1  is the SPI serial clock, idle low and asynchronous to clk.
REQ-007 SDI  input  1  is the SPI serial data, driven by the master on SCK falling edges.
REQ-008 rx_word  output  16  holds the last accepted frame, with bit 0 being the first bit received.
REQ-009 rx_cfg  output  4  equals rx_word[3:0].
REQ-010 rx_data  output  8  equals rx_word[11:4].
REQ-011 rx_valid  output  1  is a single-cycle pulse indicating that a new frame was accepted.
REQ-012 rx_err  output  1  is a single-cycle pulse indicating that a frame was rejected.
REQ-013 busy  output  1  is high while a frame is in progress (state SHIFT).

Function
REQ-014 n_CS, SCK and SDI shall each pass through a SYNC_STAGES flip-flop synchronizer; the synchronizers for n_CS and SCK shall reset to 1 and 0 respectively.
REQ-015 A synchronized SCK 0->1 transition shall be a sample event; a synchronized n_CS 1->0 transition shall be a frame start; a synchronized n_CS 0->1 transition shall be a frame end.
REQ-016 Framing is SPI mode 0, LSB first: the k-th sample event after a frame start (k = 0..15) shall write the synchronized SDI value into shift bit k.
REQ-017 The FSM states are IDLE, SHIFT and ABORT.
REQ-018 IDLE -> SHIFT on frame start; on entry the bit counter and shift register shall be cleared.
REQ-019 SHIFT: each sample event with count < FRAME_BITS shall store the bit and increment the counter.
REQ-020 SHIFT: a sample event with count = FRAME_BITS (overrun) shall move the FSM to ABORT.
REQ-021 SHIFT -> IDLE on frame end.
REQ-022 On a frame end in SHIFT, the frame is accepted if the counter equals FRAME_BITS and shift bits [15:12] are 0000; otherwise it is rejected.
REQ-023 On acceptance, rx_word shall be loaded and rx_valid shall pulse in the same cycle, exactly one clk after the frame-end detection.
REQ-024 On rejection, rx_word shall hold its previous value and rx_err shall pulse, with the same timing as rx_valid.
REQ-025 ABORT shall ignore sample events; on frame end it shall pulse rx_err and return to IDLE.
REQ-026 rx_valid and rx_err shall never be high in the same cycle.
REQ-027 Sample events while in IDLE shall be ignored.
REQ-028 If a frame end and a sample event are detected in the same cycle, the frame end shall take priority and the sample shall be discarded.
REQ-029 A frame start detected in the cycle immediately after an accept or reject pulse shall be honored, so back-to-back frames lose no bits.
REQ-030 Latency from an SDI/SCK pin edge to storage shall be SYNC_STAGES+1 clk; correct operation requires SCK high and SCK low each to last at least SYNC_STAGES+2 clk periods.

Reset
REQ-031 While rst = 0, asynchronously: FSM = IDLE, counter = 0, shift register = 0, rx_word = 0x0000, rx_valid = 0, rx_err = 0, busy = 0.
REQ-032 If reset is asserted mid-frame, the frame in progress shall be discarded with no pulse, both on reset entry and on release.
REQ-033 After reset release with n_CS already low, no frame start shall be detected until n_CS has been seen high and then low again.

Verification
REQ-034 Frame 0x078C (data 120, cfg 1100), LSB first, 16 SCK cycles of 6 clk each high and 6 clk each low -> rx_valid pulses once; rx_data = 0x78; rx_cfg = 0xC; rx_word = 0x078C.
REQ-035 Frame with only 15 SCK rising edges, then n_CS goes high -> rx_err pulses once; rx_word holds its prior value; rx_valid stays 0.
REQ-036 17 SCK rising edges in one frame -> FSM reaches ABORT; on n_CS high, rx_err pulses once; no rx_valid.
REQ-037 Frame 0xF78C (nonzero upper nibble) -> rx_err pulses; rx_word unchanged.
REQ-038 Reset pulsed low after 8 bits, then a full frame 0x0123 -> no pulse on reset; the full frame yields rx_valid with rx_word = 0x0123.
REQ-039 Two frames 0x078C then 0x0055, with n_CS high for 4 clk between them -> two rx_valid pulses; final rx_word = 0x0055.

Source files
------------

// File: rtl/spi_dac_rx.sv
// spi_dac_rx: SPI mode-0, LSB-first frame receiver with input synchronizers and frame validation.
module spi_dac_rx #(
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        n_CS,
    input  logic        SCK,
    input  logic        SDI,
    output logic [15:0] rx_word,
    output logic [3:0]  rx_cfg,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_err,
    output logic        busy
);
    localparam int SW = FRAME_BITS > 16 ? FRAME_BITS : 16;
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] FB = CW'(FRAME_BITS);
    typedef enum logic [1:0] {IDLE, SHIFT, ABORT} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] cs_q, sck_q, sdi_q, vld_q;
    logic cs_prev, sck_prev, armed;
    logic [CW-1:0] cnt;
    logic [SW-1:0] sh;
    logic cs_s, sck_s, sdi_s, f_start, f_end, sample;
    assign cs_s    = cs_q[SYNC_STAGES-1];
    assign sck_s   = sck_q[SYNC_STAGES-1];
    assign sdi_s   = sdi_q[SYNC_STAGES-1];
    // armed only once a genuine high n_CS has been seen, so a low n_CS at reset release starts nothing
    assign f_start = armed & cs_prev & ~cs_s;
    assign f_end   = ~cs_prev & cs_s;
    assign sample  = ~sck_prev & sck_s;
    assign rx_cfg  = rx_word[3:0];
    assign rx_data = rx_word[11:4];
    assign busy    = state == SHIFT;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_q     <= '1;
            sck_q    <= '0;
            sdi_q    <= '0;
            vld_q    <= '0;
            cs_prev  <= 1'b1;
            sck_prev <= 1'b0;
            armed    <= 1'b0;
        end else begin
            cs_q     <= {cs_q[SYNC_STAGES-2:0], n_CS};
            sck_q    <= {sck_q[SYNC_STAGES-2:0], SCK};
            sdi_q    <= {sdi_q[SYNC_STAGES-2:0], SDI};
            vld_q    <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            cs_prev  <= cs_s;
            sck_prev <= sck_s;
            armed    <= armed | (vld_q[SYNC_STAGES-1] & cs_s);
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sh       <= '0;
            rx_word  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            case (state)
                IDLE: if (f_start) begin
                    state <= SHIFT;
                    cnt   <= '0;
                    sh    <= '0;
                end
                SHIFT: if (f_end) begin
                    state <= IDLE;
                    if (cnt == FB && sh[15:12] == 4'b0000) begin
                        rx_word  <= sh[15:0];
                        rx_valid <= 1'b1;
                    end else rx_err <= 1'b1;
                end else if (sample) begin
                    if (cnt < FB) begin
                        sh  <= sh | (SW'(sdi_s) << cnt);
                        cnt <= cnt + CW'(1);
                    end else state <= ABORT;
                end
                ABORT: if (f_end) begin
                    state  <= IDLE;
                    rx_err <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
